// File: rtl/bcd_rate_counter.sv
// bcd_rate_counter: rate-selectable multi-digit BCD up/down counter driven by
// clock enables derived from one system clock (no derived clocks).
// Latency: a rate tick in cycle n updates bcd/step/wrap at the edge ending cycle n.
// Backpressure: none; load has priority over counting, en=0 holds the count.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   sw            rate select (values >= N_RATES select the fastest rate)
//   mode          0 = up, 1 = down
//   en            counting allowed
//   load/load_val synchronous load of a packed BCD value (clamped to MAX_COUNT)
//   bcd           packed BCD count, digit 0 in [3:0]
//   step, wrap    one-cycle pulses marking a new count / a wrap-around
//
// Build option: define BCD_RATE_COUNTER_SAT_EN to saturate at 0 / MAX_COUNT
// instead of wrapping.

module bcd_rate_counter #(
  parameter int CLK_HZ    = 50000000,
  parameter int BASE_HZ   = 2,
  parameter int N_RATES   = 4,
  parameter int DIGITS    = 2,
  parameter int MAX_COUNT = 29,
  localparam int SW_W     = (N_RATES > 1) ? $clog2(N_RATES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SW_W-1:0]       sw,
  input  logic                  mode,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  step,
  output logic                  wrap
);

  localparam int P  = CLK_HZ / (BASE_HZ * (1 << (N_RATES - 1)));
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int CW = (N_RATES > 1) ? N_RATES - 1 : 1;
  localparam int BW = 4 * DIGITS;

  function automatic logic [BW-1:0] to_bcd(input int value);
    logic [BW-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [BW-1:0] MAX_BCD = to_bcd(MAX_COUNT);

  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] chain_q, chain_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic          step_q, step_d;
  logic          wrap_q, wrap_d;

  logic          fast_tick;
  logic          rate_tick;
  logic [CW-1:0] tick_mask;
  int            sel_i;
  logic [BW-1:0] bcd_inc, bcd_dec;
  logic          inc_carry, dec_borrow;
  logic          at_max, at_zero;
  logic          load_ok;

  // Prescaler and chain free-run; only rst stops them.
  always_comb begin
    fast_tick = (presc_q == PW'(P - 1));
    presc_d   = fast_tick ? '0 : presc_q + 1'b1;
    chain_d   = fast_tick ? chain_q + 1'b1 : chain_q;
  end

  // Rate k fires on fast_tick when the low (N_RATES-1-k) chain bits are all
  // ones. Since ticks only exist on fast_tick, an sw change can only take
  // effect at a fast_tick boundary, so no runt steps are possible.
  always_comb begin
    sel_i = (int'(sw) >= N_RATES) ? N_RATES - 1 : int'(sw);
    tick_mask = '0;
    for (int b = 0; b < CW; b++) begin
      if (b < N_RATES - 1 - sel_i) tick_mask[b] = 1'b1;
    end
    rate_tick = fast_tick && ((chain_q & tick_mask) == tick_mask);
  end

  // Decimal increment / decrement with ripple carry / borrow across digits.
  always_comb begin
    bcd_inc    = bcd_q;
    bcd_dec    = bcd_q;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (bcd_q[4*i +: 4] >= 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          inc_carry = 1'b0;
        end
      end
      if (dec_borrow) begin
        if (bcd_q[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
          dec_borrow = 1'b0;
        end
      end
    end
  end

  // With every digit valid, packed BCD compares like the decimal value.
  always_comb begin
    at_max  = (bcd_q == MAX_BCD);
    at_zero = (bcd_q == '0);
    load_ok = (load_val <= MAX_BCD);
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  always_comb begin
    bcd_d  = bcd_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (load) begin
      bcd_d = load_ok ? load_val : MAX_BCD;
    end else if (en && rate_tick) begin
      if (!mode) begin
        if (at_max) begin
`ifdef BCD_RATE_COUNTER_SAT_EN
          bcd_d = bcd_q;
`else
          bcd_d  = '0;
          step_d = 1'b1;
          wrap_d = 1'b1;
`endif
        end else begin
          bcd_d  = bcd_inc;
          step_d = 1'b1;
        end
      end else begin
        if (at_zero) begin
`ifdef BCD_RATE_COUNTER_SAT_EN
          bcd_d = bcd_q;
`else
          bcd_d  = MAX_BCD;
          step_d = 1'b1;
          wrap_d = 1'b1;
`endif
        end else begin
          bcd_d  = bcd_dec;
          step_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      chain_q <= '0;
      bcd_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      chain_q <= chain_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bcd  = bcd_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: doc/bcd_rate_counter.md
# bcd_rate_counter

Parametrised rate-selectable BCD up/down counter for the board display path: divides the 50 MHz system clock internally into a bank of power-of-two tick rates, steps a multi-digit BCD count at the selected rate, and presents packed BCD digits directly to the TM1638 display driver. It replaces the separate divider, clock mux, modulo counter and hex-to-BCD stages with a single-clock block that uses clock enables only, with no derived clocks.

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- BASE_HZ, 2, slowest step rate in Hz (rate index 0)
- N_RATES, 4, number of selectable rates; rate k = BASE_HZ·2^k
- DIGITS, 2, number of BCD digits in the count
- MAX_COUNT, 29, decimal terminal value; must be < 10^DIGITS
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous reset, active-high
- sw  in  clog2(N_RATES)  rate select; values ≥ N_RATES select rate N_RATES-1
- mode  in  1  0 = count up, 1 = count down
- en  in  1  1 = counting allowed; 0 = hold count
- load  in  1  synchronous load strobe
- load_val  in  4·DIGITS  packed BCD load value, digit 0 in [3:0]
- bcd  out  4·DIGITS  packed BCD count, digit 0 (ones) in [3:0]
- step  out  1  one-cycle pulse, high in the cycle the new count first appears on bcd
- wrap  out  1  one-cycle pulse coincident with step when the count wrapped

## Operation
- Prescaler: counter modulo P = CLK_HZ / (BASE_HZ·2^(N_RATES-1)) emits fast_tick, one cycle per P cycles. An (N_RATES-1)-bit chain counter increments on each fast_tick.
- Rate tick for index k: fast_tick AND the low (N_RATES-1-k) chain bits are all ones. Index N_RATES-1 equals fast_tick.
- Prescaler and chain run continuously, independent of en, load and mode. They stop only under rst.
- Count update priority, evaluated per cycle: rst > load > (en AND rate tick) > hold.
- Up: ones digit +1 with decimal carry into higher digits. At MAX_COUNT the next value is 0 and wrap is asserted.
- Down: decimal borrow. At 0 the next value is MAX_COUNT and wrap is asserted.
- Load: load_val is taken if every digit ≤ 9 and the value ≤ MAX_COUNT. Otherwise MAX_COUNT is loaded. Load never asserts step or wrap.
- A mode change takes effect on the next step. No extra step is generated.
- An sw change takes effect at the next fast_tick boundary. No runt or double step is generated.
- bcd digits are always valid BCD (0–9) and never exceed MAX_COUNT.

## Timing
- Reset values: bcd = 0, step = 0, wrap = 0, prescaler = 0, chain = 0.
- Latency: a rate tick in cycle n changes bcd at the edge ending cycle n. step and wrap are registered with the same edge and are high for exactly one cycle.
- The first fast_tick after reset occurs P cycles after rst deasserts. The first step at rate k occurs P·2^(N_RATES-1-k) cycles after rst deasserts.
- Reset mid-count: the count is cleared on the next edge, with no step pulse.
- Load and tick in the same cycle: the load wins and the tick is discarded. Counting resumes at the next tick of the running prescaler.

## Configuration
- BCD_RATE_COUNTER_SAT_EN
  - Defined: counting saturates. Up holds at MAX_COUNT and down holds at 0. wrap is never asserted. step is not asserted when the count is held at a limit.
  - Undefined: wrap-around behaviour as described in Operation.

## Test plan
All scenarios use CLK_HZ=64, BASE_HZ=2, N_RATES=4, DIGITS=2, MAX_COUNT=29, giving P=4.
- Rate select: rst pulse, then sw=3, mode=0, en=1. Required: step every 4 cycles, bcd 0x00→0x01→…, first step 4 cycles after rst. With sw=0, step every 32 cycles.
- Up wrap: load 0x28, sw=3. Required: bcd 0x29, then 0x00 with wrap=1 in that step cycle, then 0x01 with wrap=0. Decimal carry checked at 0x09→0x10 and 0x19→0x20.
- Down wrap: load 0x01, mode=1. Required: 0x00, then 0x29 with wrap=1. Borrow checked at 0x10→0x09.
- Load clamp and priority: load 0x35 gives bcd=0x29. load 0x1A gives 0x29. load asserted in a fast_tick cycle gives the load value, with no step.
- Enable, sw change and reset: en=0 for 20 cycles holds bcd with step=0 and the prescaler still running. sw changed 3→1 mid-interval produces no step closer than 4 cycles. rst mid-count gives bcd=0 next cycle.
- Saturation (BCD_RATE_COUNTER_SAT_EN defined): from 0x29 counting up, bcd stays 0x29 with no step or wrap. From 0x00 counting down, bcd stays 0x00.
